// File: rtl/maxpool2x2_stage_pkg.sv
// Shared definitions for the 2x2/stride-2 max-pool layer stage: word layout,
// FSM states and the per-lane slice helper.
package maxpool2x2_stage_pkg;

  localparam int ACT_BITS = 8;
  localparam int LANES    = 16;
  localparam int WORD_W   = ACT_BITS * LANES;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    READ,
    ACC,
    WRITE,
    DONE
  } state_e;

  function automatic logic signed [ACT_BITS-1:0] lane_of(input logic [WORD_W-1:0] word,
                                                          input int idx);
    return word[idx*ACT_BITS +: ACT_BITS];
  endfunction

endpackage

// File: rtl/maxpool2x2_stage_max16.sv
// Combinational per-lane signed max of the running accumulator against a new
// source word; on a tie the accumulator value is kept.
module pool_max16
  import maxpool2x2_stage_pkg::*;
(
  input  logic [WORD_W-1:0] acc_i,
  input  logic [WORD_W-1:0] din_i,
  output logic [WORD_W-1:0] max_o
);

  always_comb begin
    max_o = acc_i;
    for (int i = 0; i < LANES; i++) begin
      if (lane_of(din_i, i) > lane_of(acc_i, i)) begin
        max_o[i*ACT_BITS +: ACT_BITS] = din_i[i*ACT_BITS +: ACT_BITS];
      end
    end
  end

endmodule

// File: rtl/maxpool2x2_stage.sv
// 2x2 stride-2 max pooling over a 16-channel-per-word feature BRAM, started
// and finished through an ap_start/ap_done handshake.
module maxpool2x2_stage
  import maxpool2x2_stage_pkg::*;
#(
  parameter int RD_ADDR_W = 14,
  parameter int WR_ADDR_W = 14
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 ap_start,
  input  logic [8:0]           ifm_w,
  input  logic [8:0]           ifm_h,
  input  logic [8:0]           in_ch,
  output logic                 r_en,
  output logic [RD_ADDR_W-1:0] r_addr,
  input  logic                 r_data_vld,
  input  logic [WORD_W-1:0]    r_data,
  output logic                 w_en,
  output logic [WR_ADDR_W-1:0] w_addr,
  output logic [WORD_W-1:0]    w_data,
  output logic                 busy,
  output logic                 ap_done
);

  state_e               state_q;
  logic                 busy_q, done_q, r_en_q, w_en_q;
  logic [RD_ADDR_W-1:0] r_addr_q;
  logic [WR_ADDR_W-1:0] w_addr_q;
  logic [WORD_W-1:0]    w_data_q;

  logic [4:0]           g_num_q;
  logic [7:0]           ow_q, oh_q;
  logic [RD_ADDR_W-1:0] wg_q;

  logic [4:0]           g_q;
  logic [7:0]           ox_q, oy_q;
  logic [RD_ADDR_W-1:0] win_q, row_q;
  logic [1:0]           rd_idx_q;
  logic [2:0]           vcnt_q;
  logic [WORD_W-1:0]    acc_q;

  logic [13:0]          wg_prod;
  logic                 unused_cfg;
  logic [RD_ADDR_W-1:0] g_ext;
  logic                 last_g, last_ox, last_oy, all_done;
  logic [4:0]           g_nx;
  logic [7:0]           ox_nx, oy_nx;
  logic [RD_ADDR_W-1:0] win_nx, row_nx;
  logic                 take;
  logic [WORD_W-1:0]    max_w, acc_d;
  logic [2:0]           vcnt_d;
  logic                 got4;

  // Row stride in words (ifm_w*G); the only multiply, done once per start.
  assign wg_prod    = {5'd0, ifm_w} * {9'd0, in_ch[8:4]};
  assign unused_cfg = ^{in_ch[3:0], ifm_h[0]};
  assign g_ext      = RD_ADDR_W'(g_num_q);

  function automatic logic [RD_ADDR_W-1:0] src_addr(input logic [RD_ADDR_W-1:0] win,
                                                     input logic [4:0]           g,
                                                     input logic [1:0]           idx,
                                                     input logic [RD_ADDR_W-1:0] wg,
                                                     input logic [RD_ADDR_W-1:0] gs);
    return win + RD_ADDR_W'(g) + (idx[1] ? wg : '0) + (idx[0] ? gs : '0);
  endfunction

  assign last_g   = (g_q == g_num_q - 5'd1);
  assign last_ox  = (ox_q == ow_q - 8'd1);
  assign last_oy  = (oy_q == oh_q - 8'd1);
  assign all_done = last_g && last_ox && last_oy;

  assign g_nx   = last_g ? 5'd0 : g_q + 5'd1;
  assign ox_nx  = !last_g ? ox_q : (last_ox ? 8'd0 : ox_q + 8'd1);
  assign oy_nx  = (last_g && last_ox) ? oy_q + 8'd1 : oy_q;
  assign row_nx = (last_g && last_ox) ? row_q + (wg_q << 1) : row_q;
  assign win_nx = !last_g ? win_q : (last_ox ? row_nx : win_q + (g_ext << 1));

  // Returned words are only counted while a window is outstanding.
  assign take   = ((state_q == READ) || (state_q == ACC)) && r_data_vld && (vcnt_q != 3'd4);
  assign acc_d  = take ? ((vcnt_q == 3'd0) ? r_data : max_w) : acc_q;
  assign vcnt_d = take ? vcnt_q + 3'd1 : vcnt_q;
  assign got4   = (vcnt_d == 3'd4);

  pool_max16 u_max (
    .acc_i (acc_q),
    .din_i (r_data),
    .max_o (max_w)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      r_en_q   <= 1'b0;
      r_addr_q <= '0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      g_num_q  <= '0;
      ow_q     <= '0;
      oh_q     <= '0;
      wg_q     <= '0;
      g_q      <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      win_q    <= '0;
      row_q    <= '0;
      rd_idx_q <= '0;
      vcnt_q   <= '0;
      acc_q    <= '0;
    end else begin
      done_q <= 1'b0;
      w_en_q <= 1'b0;
      acc_q  <= acc_d;
      vcnt_q <= vcnt_d;
      case (state_q)
        IDLE: begin
          if (ap_start) begin
            g_num_q <= in_ch[8:4];
            ow_q    <= ifm_w[8:1];
            oh_q    <= ifm_h[8:1];
            wg_q    <= RD_ADDR_W'(wg_prod);
            busy_q  <= 1'b1;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if ((g_num_q == 5'd0) || (ow_q == 8'd0) || (oh_q == 8'd0)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            g_q      <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            win_q    <= '0;
            row_q    <= '0;
            w_addr_q <= '0;
            vcnt_q   <= '0;
            rd_idx_q <= '0;
            r_en_q   <= 1'b1;
            r_addr_q <= '0;
            state_q  <= READ;
          end
        end
        READ: begin
          if (rd_idx_q == 2'd3) begin
            r_en_q <= 1'b0;
            if (got4) begin
              w_en_q   <= 1'b1;
              w_data_q <= acc_d;
              state_q  <= WRITE;
            end else begin
              state_q <= ACC;
            end
          end else begin
            rd_idx_q <= rd_idx_q + 2'd1;
            r_addr_q <= src_addr(win_q, g_q, rd_idx_q + 2'd1, wg_q, g_ext);
          end
        end
        ACC: begin
          if (got4) begin
            w_en_q   <= 1'b1;
            w_data_q <= acc_d;
            state_q  <= WRITE;
          end
        end
        WRITE: begin
          // Destination words are produced in address order, so a counter suffices.
          w_addr_q <= w_addr_q + 1'b1;
          if (all_done) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            g_q      <= g_nx;
            ox_q     <= ox_nx;
            oy_q     <= oy_nx;
            win_q    <= win_nx;
            row_q    <= row_nx;
            vcnt_q   <= '0;
            rd_idx_q <= '0;
            r_en_q   <= 1'b1;
            r_addr_q <= src_addr(win_nx, g_nx, 2'd0, wg_q, g_ext);
            state_q  <= READ;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign r_en    = r_en_q;
  assign r_addr  = r_addr_q;
  assign w_en    = w_en_q;
  assign w_addr  = w_addr_q;
  assign w_data  = w_data_q;
  assign busy    = busy_q;
  assign ap_done = done_q;

endmodule
